ticket_dispense_arbiter: RTL and testbench

- Shares one ticket printer and one coin-change dispenser among N_KIOSK fare-calculation kiosks.
- Each kiosk raises a request once its customer has paid, carrying its ticket count and change due.
- The arbiter picks a kiosk round-robin, then sequences one print strobe per ticket and one coin pulse per coin of change (greedy 10/5/1).
- It acknowledges the kiosk with a done pulse and then serves the next requester.

---
 rtl/ticket_dispense_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_ticket_dispense_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ticket_dispense_arbiter.sv
// ticket_dispense_arbiter
// Shares one ticket printer and one coin-change dispenser among N_KIOSK fare
// kiosks. A kiosk is picked round-robin. Its ticket count and change are
// latched at grant. The arbiter then issues one print strobe per ticket and
// pays the change greedily in 10/5/1 coins, one per cycle. Finally it pulses
// done back to the kiosk. Every output comes straight from a register.
module ticket_dispense_arbiter #(
    parameter int N_KIOSK   = 4,
    parameter int PRINT_GAP = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_KIOSK-1:0]         req,
    input  logic [3*N_KIOSK-1:0]       tickets_flat,
    input  logic [7*N_KIOSK-1:0]       change_flat,
    input  logic                       print_ready,
    output logic [N_KIOSK-1:0]         grant,
    output logic [$clog2(N_KIOSK)-1:0] owner,
    output logic                       busy,
    output logic [N_KIOSK-1:0]         done,
    output logic                       print_strobe,
    output logic                       coin10,
    output logic                       coin5,
    output logic                       coin1
);
    localparam int OW = $clog2(N_KIOSK);
    localparam int GW = (PRINT_GAP > 1) ? $clog2(PRINT_GAP) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRINT,
        S_PGAP,
        S_CHANGE,
        S_DONE
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [N_KIOSK-1:0] r_grant, w_grant_nxt;
    logic [OW-1:0]      r_owner, w_owner_nxt;
    logic               r_busy, w_busy_nxt;
    logic [N_KIOSK-1:0] r_done, w_done_nxt;
    logic               r_strobe, w_strobe_nxt;
    logic               r_coin10, w_coin10_nxt;
    logic               r_coin5, w_coin5_nxt;
    logic               r_coin1, w_coin1_nxt;
    logic [2:0]         r_tix, w_tix_nxt;
    logic [6:0]         r_chg, w_chg_nxt;
    logic [GW-1:0]      r_gap, w_gap_nxt;
    logic [OW-1:0]      r_ptr, w_ptr_nxt;

    logic [OW-1:0]      w_win;
    logic [N_KIOSK-1:0] w_win_onehot;
    logic [2:0]         w_tix_raw;
    logic [2:0]         w_tix_clamp;
    logic [6:0]         w_chg_in;
    logic [OW-1:0]      w_ptr_inc;

    // Round-robin search: the requester at the smallest offset from the pointer wins.
    always_comb begin
        logic [OW-1:0] v_idx;
        v_idx = '0;
        w_win = '0;
        for (int k = N_KIOSK - 1; k >= 0; k--) begin
            v_idx = OW'((int'(r_ptr) + k) % N_KIOSK);
            if (req[v_idx]) begin
                w_win = v_idx;
            end
        end
    end

    assign w_win_onehot = N_KIOSK'(1) << w_win;
    assign w_tix_raw    = 3'(tickets_flat >> (3 * int'(w_win)));
    assign w_tix_clamp  = (w_tix_raw > 3'd5) ? 3'd5 : w_tix_raw;
    assign w_chg_in     = 7'(change_flat >> (7 * int'(w_win)));
    assign w_ptr_inc    = (r_owner == OW'(N_KIOSK - 1)) ? '0 : r_owner + 1'b1;

    // Next-state and next-output logic for the service sequencer.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        w_state_nxt  = r_state;
        w_grant_nxt  = r_grant;
        w_owner_nxt  = r_owner;
        w_busy_nxt   = r_busy;
        w_done_nxt   = '0;
        w_strobe_nxt = 1'b0;
        w_coin10_nxt = 1'b0;
        w_coin5_nxt  = 1'b0;
        w_coin1_nxt  = 1'b0;
        w_tix_nxt    = r_tix;
        w_chg_nxt    = r_chg;
        w_gap_nxt    = r_gap;
        w_ptr_nxt    = r_ptr;

        case (r_state)
            S_IDLE: begin
                if (|req) begin
                    w_grant_nxt = w_win_onehot;
                    w_owner_nxt = w_win;
                    w_busy_nxt  = 1'b1;
                    w_tix_nxt   = w_tix_clamp;
                    w_chg_nxt   = w_chg_in;
                    w_state_nxt = (w_tix_clamp != 3'd0) ? S_PRINT : S_CHANGE;
                end
            end
            S_PRINT: begin
                if (print_ready) begin
                    w_strobe_nxt = 1'b1;
                    w_tix_nxt    = r_tix - 3'd1;
                    w_gap_nxt    = GW'(PRINT_GAP - 1);
                    w_state_nxt  = S_PGAP;
                end
            end
            S_PGAP: begin
                if (r_gap == '0) begin
                    w_state_nxt = (r_tix != 3'd0) ? S_PRINT : S_CHANGE;
                end else begin
                    w_gap_nxt = r_gap - 1'b1;
                end
            end
            S_CHANGE: begin
                if (r_chg >= 7'd10) begin
                    w_coin10_nxt = 1'b1;
                    w_chg_nxt    = r_chg - 7'd10;
                end else if (r_chg >= 7'd5) begin
                    w_coin5_nxt = 1'b1;
                    w_chg_nxt   = r_chg - 7'd5;
                end else if (r_chg != 7'd0) begin
                    w_coin1_nxt = 1'b1;
                    w_chg_nxt   = r_chg - 7'd1;
                end else begin
                    w_done_nxt  = r_grant;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_grant_nxt = '0;
                w_busy_nxt  = 1'b0;
                w_ptr_nxt   = w_ptr_inc;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State and output registers; reset aborts any transaction at once.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
        if (reset) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_owner  <= '0;
            r_busy   <= 1'b0;
            r_done   <= '0;
            r_strobe <= 1'b0;
            r_coin10 <= 1'b0;
            r_coin5  <= 1'b0;
            r_coin1  <= 1'b0;
            r_tix    <= '0;
            r_chg    <= '0;
            r_gap    <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_grant  <= w_grant_nxt;
            r_owner  <= w_owner_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_strobe <= w_strobe_nxt;
            r_coin10 <= w_coin10_nxt;
            r_coin5  <= w_coin5_nxt;
            r_coin1  <= w_coin1_nxt;
            r_tix    <= w_tix_nxt;
            r_chg    <= w_chg_nxt;
            r_gap    <= w_gap_nxt;
            r_ptr    <= w_ptr_nxt;
        end
    end

    assign grant        = r_grant;
    assign owner        = r_owner;
    assign busy         = r_busy;
    assign done         = r_done;
    assign print_strobe = r_strobe;
    assign coin10       = r_coin10;
    assign coin5        = r_coin5;
    assign coin1        = r_coin1;

endmodule

// File: tb/tb_ticket_dispense_arbiter.sv
// tb_ticket_dispense_arbiter
// Directed bench. A table of single transactions comes first. Each row gives
// the request, ticket and change inputs, together with hand-computed strobe
// and coin counts and the done cycle. Cycle 1 is the first cycle after the
// edge that samples req. Hand-written sequences then cover round-robin,
// printer stall, req drop, reset abort and fairness.
module tb_ticket_dispense_arbiter;
    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   req;
    logic [3*N-1:0] tickets_flat;
    logic [7*N-1:0] change_flat;
    logic           print_ready;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic [N-1:0]   done;
    logic           print_strobe;
    logic           coin10;
    logic           coin5;
    logic           coin1;

    ticket_dispense_arbiter #(
        .N_KIOSK   (N),
        .PRINT_GAP (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .tickets_flat (tickets_flat),
        .change_flat  (change_flat),
        .print_ready  (print_ready),
        .grant        (grant),
        .owner        (owner),
        .busy         (busy),
        .done         (done),
        .print_strobe (print_strobe),
        .coin10       (coin10),
        .coin5        (coin5),
        .coin1        (coin1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        int           owner;
        int           tix;
        int           chg;
        int           e_strobes;
        int           e_c10;
        int           e_c5;
        int           e_c1;
        int           e_done_t;
    } vec_t;

    vec_t vecs[6];

    int total = 0;
    int bad   = 0;
    int excl_bad = 0;
    int spacing_bad = 0;
    int order_bad = 0;

    int           n_strobe, n10, n5, n1;
    int           first_strobe, last_strobe, last_coin_t, last_coin_val;
    int           done_t;
    logic [N-1:0] done_val;
    logic [N-1:0] g1;
    logic [1:0]   o1;
    logic         b1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if ((int'(print_strobe) + int'(coin10) + int'(coin5) + int'(coin1)) > 1) excl_bad++;
    endtask

    task automatic set_kiosk(input int i, input int t, input int c);
        tickets_flat[3*i +: 3] = 3'(t);
        change_flat[7*i +: 7]  = 7'(c);
    endtask

    // Target kiosk gets the row's values; the others get distinct decoys.
    task automatic fill_inputs(input int who, input int t, input int c);
        for (int i = 0; i < N; i++) begin
            if (i == who) set_kiosk(i, t, c);
            else set_kiosk(i, 6, 40 + i);
        end
    endtask

    // Run until the first done pulse (bounded), collecting pulse statistics.
    task automatic observe(input int limit);
        int cv;
        n_strobe = 0; n10 = 0; n5 = 0; n1 = 0;
        first_strobe = 0; last_strobe = 0; last_coin_t = 0; last_coin_val = 100;
        done_t = 0; done_val = '0; g1 = '0; o1 = '0; b1 = 1'b0;
        for (int t = 1; t <= limit && done_t == 0; t++) begin
            tick();
            if (t == 1) begin
                g1 = grant; o1 = owner; b1 = busy;
            end
            if (print_strobe) begin
                n_strobe++;
                if (first_strobe == 0) first_strobe = t;
                else if (t - last_strobe != 4) spacing_bad++;
                last_strobe = t;
            end
            if (coin10 | coin5 | coin1) begin
                cv = coin10 ? 10 : (coin5 ? 5 : 1);
                if (coin10) n10++;
                if (coin5) n5++;
                if (coin1) n1++;
                if (cv > last_coin_val) order_bad++;
                if (last_coin_t != 0 && t - last_coin_t != 1) spacing_bad++;
                last_coin_t = t;
                last_coin_val = cv;
            end
            if (done != '0) begin
                done_t = t;
                done_val = done;
            end
        end
    endtask

    task automatic check_cleared(input string name);
        tick();
        check({name, " cleared"}, 32'({grant, busy, done}), 32'(0));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [N-1:0] oh;
        logic [N-1:0] rr_exp[5];
        logic [N-1:0] rr_done[5];
        logic [N-1:0] rr_grant[5];
        logic [N-1:0] fr_exp[3];
        logic [N-1:0] fr_done[3];
        int got;
        int stall_strobes;
        int stall_lost;
        int rst_done;

        vecs[0] = '{4'b0100, 2, 3, 17,  3, 1,  1, 2, 18};
        vecs[1] = '{4'b0001, 0, 0, 0,   0, 0,  0, 0, 2};
        vecs[2] = '{4'b1000, 3, 7, 127, 5, 12, 1, 2, 37};
        vecs[3] = '{4'b0010, 1, 1, 9,   1, 0,  1, 4, 11};
        vecs[4] = '{4'b0011, 0, 2, 10,  2, 1,  0, 0, 11};
        vecs[5] = '{4'b1001, 3, 5, 0,   5, 0,  0, 0, 22};

        reset = 1'b0;
        req = '0;
        tickets_flat = '0;
        change_flat = '0;
        print_ready = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("reset outputs", 32'({grant, owner, busy, done, print_strobe, coin10, coin5, coin1}), 32'(0));
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle no grant", 32'({grant, busy}), 32'(0));

        // Table of single transactions, each starting from IDLE.
        for (int r = 0; r < 6; r++) begin
            fill_inputs(vecs[r].owner, vecs[r].tix, vecs[r].chg);
            req = vecs[r].req;
            observe(80);
            req = '0;
            oh = 4'b0001 << vecs[r].owner;
            check($sformatf("v%0d grant", r), 32'(g1), 32'(oh));
            check($sformatf("v%0d owner", r), 32'(o1), 32'(vecs[r].owner));
            check($sformatf("v%0d busy", r), 32'(b1), 32'(1));
            check($sformatf("v%0d strobes", r), n_strobe, vecs[r].e_strobes);
            if (vecs[r].tix > 0) check($sformatf("v%0d first strobe", r), first_strobe, 2);
            check($sformatf("v%0d coin10", r), n10, vecs[r].e_c10);
            check($sformatf("v%0d coin5", r), n5, vecs[r].e_c5);
            check($sformatf("v%0d coin1", r), n1, vecs[r].e_c1);
            check($sformatf("v%0d done cycle", r), done_t, vecs[r].e_done_t);
            check($sformatf("v%0d done kiosk", r), 32'(done_val), 32'(oh));
            check_cleared($sformatf("v%0d", r));
        end

        // All four kiosks request together and hold; pointer starts at 0.
        do_reset();
        for (int i = 0; i < N; i++) set_kiosk(i, 0, 0);
        rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
        req = 4'b1111;
        got = 0;
        for (int c = 0; c < 60 && got < 5; c++) begin
            tick();
            if (done != '0) begin
                rr_done[got] = done;
                rr_grant[got] = grant;
                got++;
                if (got == 5) req = '0;
            end
        end
        check("rr done count", got, 5);
        for (int i = 0; i < got; i++) begin
            check($sformatf("rr done %0d", i), 32'(rr_done[i]), 32'(rr_exp[i]));
            check($sformatf("rr grant %0d", i), 32'(rr_grant[i]), 32'(rr_exp[i]));
        end
        tick();

        // Printer stall: print_ready low for 20 cycles while in PRINT.
        print_ready = 1'b0;
        fill_inputs(0, 2, 0);
        req = 4'b0001;
        tick();
        check("stall grant", 32'(grant), 32'(4'b0001));
        req = '0;
        stall_strobes = 0;
        stall_lost = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (print_strobe) stall_strobes++;
            if (!busy || grant != 4'b0001) stall_lost++;
        end
        check("stall strobes", stall_strobes, 0);
        check("stall held", stall_lost, 0);
        print_ready = 1'b1;
        observe(60);
        check("stall first strobe", first_strobe, 1);
        check("stall strobes total", n_strobe, 2);
        check("stall done cycle", done_t, 9);
        check("stall done kiosk", 32'(done_val), 32'(4'b0001));
        check_cleared("stall");

        // Kiosk 1 drops req while in PRINT; the service still completes.
        fill_inputs(1, 2, 6);
        req = 4'b0010;
        tick();
        check("drop grant", 32'(grant), 32'(4'b0010));
        req = '0;
        observe(60);
        check("drop strobes", n_strobe, 2);
        check("drop coin10", n10, 0);
        check("drop coin5", n5, 1);
        check("drop coin1", n1, 1);
        check("drop done cycle", done_t, 11);
        check("drop done kiosk", 32'(done_val), 32'(4'b0010));
        check_cleared("drop");

        // Reset asserted mid-CHANGE on kiosk 3 aborts at once.
        fill_inputs(3, 0, 50);
        req = 4'b1000;
        tick();
        check("abort grant", 32'(grant), 32'(4'b1000));
        tick();
        tick();
        check("abort mid coin", 32'(coin10), 32'(1));
        #2 reset = 1'b1;
        #1;
        check("abort async clear", 32'({grant, owner, busy, done, print_strobe, coin10, coin5, coin1}), 32'(0));
        rst_done = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            if (done != '0 || busy) rst_done++;
        end
        check("abort quiet in reset", rst_done, 0);
        reset = 1'b0;
        fill_inputs(1, 0, 0);
        req = 4'b1010;
        observe(20);
        req = '0;
        check("abort ptr zero grant", 32'(g1), 32'(4'b0010));
        check("abort next done cycle", done_t, 2);
        check("abort next done kiosk", 32'(done_val), 32'(4'b0010));
        check_cleared("abort");

        // Fairness: kiosk 0 requests continuously, kiosk 3 joins once.
        do_reset();
        for (int i = 0; i < N; i++) set_kiosk(i, 0, 0);
        fr_exp[0] = 4'b0001; fr_exp[1] = 4'b1000; fr_exp[2] = 4'b0001;
        req = 4'b0001;
        tick();
        check("fair first grant", 32'(grant), 32'(4'b0001));
        req = 4'b1001;
        got = 0;
        for (int c = 0; c < 40 && got < 3; c++) begin
            tick();
            if (done != '0) begin
                fr_done[got] = done;
                got++;
                if (done == 4'b1000) req = 4'b0001;
                if (got == 3) req = '0;
            end
        end
        check("fair done count", got, 3);
        for (int i = 0; i < got; i++) begin
            check($sformatf("fair done %0d", i), 32'(fr_done[i]), 32'(fr_exp[i]));
        end
        tick();

        check("one pulse per cycle", excl_bad, 0);
        check("pulse spacing", spacing_bad, 0);
        check("greedy coin order", order_bad, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
